// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding, default widths and a clog2 helper shared by the fetch unit.
// Defining FETCH_MISALIGN_CHECK_EN adds the FAULT state.
package fetch_pkg;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_PC_STEP = 4;
`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush and occupancy count; head reads as 0 when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clock) begin
        if (reset && !flush && push) mem[wr_ptr] <= din;
    end
    assign dout = (count != '0) ? mem[rd_ptr] : '0;
    // Callers bound occupancy by credit, so a push into a full queue without a pop is a design bug.
    assert property (@(posedge clock) disable iff (!reset) !(push && !pop && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with credit-limited requests, in-order queue and redirect flush.
// Defining FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets into a sticky FAULT state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int PC_STEP = DEF_PC_STEP
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  fetch_fault
);
    localparam int CW = clog2(QUEUE_DEPTH) + 1;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] pc, pcq_dout;
    logic [CW-1:0] drop_count, q_count, outstanding;
    logic [INST_WIDTH+ADDR_WIDTH-1:0] q_dout;
    logic running, redirect, credit_ok, fire, resp_drop, resp_take, pop, flush;
    assign running = state == RUN;
    assign redirect = running && redirect_valid;
    assign credit_ok = (CW+1)'(q_count) + (CW+1)'(outstanding) < (CW+1)'(QUEUE_DEPTH);
    assign fire = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && drop_count != '0;
    assign resp_take = imem_resp_valid && drop_count == '0 && running && !redirect;
    assign pop = inst_valid && inst_ready && !redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << clog2(PC_STEP)) - 1);
    logic misaligned;
    assign misaligned = (redirect_target & ALIGN_MASK) != '0;
`endif
    always_ff @(posedge clock) begin
        state <= !reset ? IDLE : state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? RUN : state;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect && misaligned) state_n = FAULT;
`endif
    end
    always_comb begin
        imem_req_valid = running && credit_ok && !redirect;
`ifdef FETCH_MISALIGN_CHECK_EN
        flush = redirect || state == FAULT;
        fetch_fault = state == FAULT;
`else
        flush = redirect;
        fetch_fault = 1'b0;
`endif
    end
    // Everything still in flight at a redirect becomes a response to discard, less any arriving now.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_VECTOR;
            drop_count <= '0;
        end else begin
            if (redirect) pc <= redirect_target;
            else if (fire) pc <= pc + ADDR_WIDTH'(PC_STEP);
            if (redirect) drop_count <= drop_count + outstanding - CW'(imem_resp_valid);
            else if (resp_drop) drop_count <= drop_count - 1'b1;
        end
    end
    // The PC FIFO holds one entry per live request, so its count doubles as the outstanding counter.
    fetch_queue #(.WIDTH(ADDR_WIDTH), .DEPTH(QUEUE_DEPTH)) u_pc_fifo (
        .clock(clock), .reset(reset), .flush(flush), .push(fire), .din(pc),
        .pop(resp_take), .dout(pcq_dout), .count(outstanding)
    );
    fetch_queue #(.WIDTH(INST_WIDTH + ADDR_WIDTH), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
        .clock(clock), .reset(reset), .flush(flush), .push(resp_take), .din({imem_resp_data, pcq_dout}),
        .pop(pop), .dout(q_dout), .count(q_count)
    );
    assign inst_valid = q_count != '0;
    assign imem_addr = pc;
    assign inst_data = q_dout[ADDR_WIDTH +: INST_WIDTH];
    assign inst_pc = q_dout[ADDR_WIDTH-1:0];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table, corner sequences and randomized traffic checked against a stream-level model.
module tb_fetch_unit;
    localparam int QD = 4;
    logic clock = 0, reset = 0;
    logic imem_req_valid, imem_req_ready = 1, imem_resp_valid = 0;
    logic [31:0] imem_addr, imem_resp_data = '0, redirect_target = '0, inst_data, inst_pc;
    logic redirect_valid = 0, inst_valid, inst_ready = 0, fetch_fault;

    fetch_unit dut (
        .clock(clock), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );
    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
    typedef struct { bit ready; bit rv; logic [31:0] addr; bit iv; logic [31:0] pc; } vec_t;
    mreq_t memq[$];
    vec_t tbl[6];
    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1, owned = 0, avail = 0, fires = 0;
    int checks = 0, failures = 0;
    bit run = 0, fault = 0;
    logic [31:0] exp_req = '0, exp_pc = '0;
    logic s_rv, s_iv, s_ff;
    logic [31:0] s_addr, s_pc, s_data;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0F0F) + {a[7:0], a[31:8]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive memory, compare outputs against the model at negedge, advance the model at posedge.
    task automatic cycle();
        bit redir, exp_rv, dlv;
        mreq_t m;
        int due;
        if (memq.size() > 0 && memq[0].due == cyc) begin
            imem_resp_valid = 1;
            imem_resp_data = word(memq[0].addr);
        end else begin
            imem_resp_valid = 0;
            imem_resp_data = '0;
        end
        @(negedge clock);
        s_rv = imem_req_valid; s_addr = imem_addr; s_iv = inst_valid;
        s_pc = inst_pc; s_data = inst_data; s_ff = fetch_fault;
        redir = run && !fault && redirect_valid;
        exp_rv = run && !fault && owned < QD && !redir;
        check("req_valid", s_rv, exp_rv);
        if (exp_rv) check("req_addr", s_addr, exp_req);
        check("inst_valid", s_iv, avail > 0);
        if (avail > 0 && s_iv) begin
            check("inst_pc", s_pc, exp_pc);
            check("inst_data", s_data, word(exp_pc));
        end
        check("fetch_fault", s_ff, fault);
        @(posedge clock);
        if (!reset) begin
            memq.delete();
            last_due = cyc;
            run = 0; fault = 0; owned = 0; avail = 0; fires = 0;
            exp_req = '0; exp_pc = '0;
        end else begin
            dlv = 0;
            if (imem_resp_valid) begin
                m = memq.pop_front();
                dlv = run && !fault && !m.stale && !redir;
            end
            if (s_rv && imem_req_ready) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                m.addr = s_addr; m.due = due; m.stale = 0;
                memq.push_back(m);
                fires++;
            end
            if (exp_rv && imem_req_ready) begin
                owned++;
                exp_req += 4;
            end
            if (s_iv && inst_ready && !redir && avail > 0) begin
                avail--; owned--; exp_pc += 4;
            end
            if (dlv) avail++;
            if (redir) begin
                foreach (memq[i]) memq[i].stale = 1;
                owned = 0; avail = 0;
                exp_req = redirect_target; exp_pc = redirect_target;
`ifdef FETCH_MISALIGN_CHECK_EN
                if ((redirect_target & 32'h3) != 0) fault = 1;
`endif
            end
            run = 1;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset = 0; redirect_valid = 0; imem_req_ready = 1; inst_ready = 0;
        cycle();
        cycle();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_fetch_fault", fetch_fault, 0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        reset = 1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] want_pc);
        int n = 0;
        while (!s_iv && n < 20) begin cycle(); n++; end
        check({name, "_seen"}, s_iv, 1);
        check(name, s_pc, want_pc);
    endtask

    initial begin
        tbl[0] = '{1, 0, 32'h0, 0, 32'h0};
        tbl[1] = '{1, 1, 32'h0, 0, 32'h0};
        tbl[2] = '{1, 1, 32'h4, 0, 32'h0};
        tbl[3] = '{1, 1, 32'h8, 1, 32'h0};
        tbl[4] = '{1, 1, 32'hC, 1, 32'h4};
        tbl[5] = '{1, 1, 32'h10, 1, 32'h8};

        // Latency 1, decode always ready: consecutive addresses, first delivery three cycles after release.
        do_reset();
        foreach (tbl[i]) begin
            inst_ready = tbl[i].ready;
            cycle();
            check("tbl_req_valid", s_rv, tbl[i].rv);
            check("tbl_req_addr", s_addr, tbl[i].addr);
            check("tbl_inst_valid", s_iv, tbl[i].iv);
            if (tbl[i].iv) check("tbl_inst_pc", s_pc, tbl[i].pc);
        end

        // Redirect together with an arriving response and a pop.
        redirect_valid = 1; redirect_target = 32'h200;
        cycle();
        check("rdp_resp_arrives", imem_resp_valid, 1);
        check("rdp_pop_offered", s_iv, 1);
        check("rdp_no_request", s_rv, 0);
        redirect_valid = 0;
        cycle();
        check("rdp_flushed", s_iv, 0);
        check("rdp_new_addr", s_addr, 32'h200);
        wait_valid("rdp_first_pc", 32'h200);

        // Decode stalled: credit stops issue after QUEUE_DEPTH requests.
        do_reset();
        repeat (12) cycle();
        check("stall_fires", fires, QD);
        check("stall_req_valid", s_rv, 0);
        check("stall_pc", s_addr, 32'h10);
        inst_ready = 1;
        begin
            int n = 0;
            cycle();
            while (!s_rv && n < 10) begin cycle(); n++; end
            check("resume_req_valid", s_rv, 1);
            check("resume_addr", s_addr, 32'h10);
        end

        // Latency 3, redirect with two requests in flight.
        lat_min = 3; lat_max = 3;
        do_reset();
        inst_ready = 1;
        cycle(); cycle(); cycle();
        check("lat3_outstanding", memq.size(), 2);
        redirect_valid = 1; redirect_target = 32'h100;
        cycle();
        redirect_valid = 0;
        cycle();
        check("lat3_flushed", s_iv, 0);
        wait_valid("lat3_first_pc", 32'h100);
        repeat (6) cycle();

        // Address wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        do_reset();
        cycle();
        redirect_valid = 1; redirect_target = 32'hFFFF_FFF8;
        cycle();
        redirect_valid = 0;
        cycle(); check("wrap_a0", s_addr, 32'hFFFF_FFF8);
        cycle(); check("wrap_a1", s_addr, 32'hFFFF_FFFC);
        cycle(); check("wrap_a2", s_addr, 32'h0);
        repeat (6) cycle();

        // Misaligned redirect target.
        do_reset();
        cycle(); cycle();
        redirect_valid = 1; redirect_target = 32'h102;
        cycle();
        redirect_valid = 0;
        cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_fault", s_ff, 1);
        repeat (8) begin cycle(); check("mis_no_req", s_rv, 0); end
        do_reset();
        cycle(); cycle();
        check("mis_restart_valid", s_rv, 1);
        check("mis_restart_addr", s_addr, 32'h0);
`else
        check("mis_no_fault", s_ff, 0);
        check("mis_addr_kept", s_addr, 32'h102);
        repeat (6) cycle();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) lat_max = $urandom_range(1, 4);
            imem_req_ready = $urandom_range(0, 3) != 0;
            inst_ready = $urandom_range(0, 2) != 0;
            redirect_valid = $urandom_range(0, 24) == 0;
            redirect_target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4)
                                                          : ($urandom & 32'hFFFF_FFFC);
            reset = $urandom_range(0, 499) != 0;
            cycle();
        end
        reset = 1; redirect_valid = 0;
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle fetch path (program counter, +4 adder and instruction ROM wired directly to decode).
- Decouples fetch from decode: issues PC requests to an instruction memory with variable latency (≥1 cycle), buffers returned instructions in an in-order queue and presents them with their PC over a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and dropping in-flight responses.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width.
- INST_WIDTH, 32, instruction word width.
- QUEUE_DEPTH, 4, instruction queue entries, power of two, ≥2; also the outstanding-request credit limit.
- RESET_VECTOR, 0, PC loaded at reset.
- PC_STEP, 4, PC increment per instruction, in bytes.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  ADDR_WIDTH  request address.
- imem_resp_valid  input  1  response valid; responses return in request order.
- imem_resp_data  input  INST_WIDTH  returned instruction.
- redirect_valid  input  1  branch/jump taken.
- redirect_target  input  ADDR_WIDTH  new PC.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  INST_WIDTH  head instruction.
- inst_pc  output  ADDR_WIDTH  PC of the head instruction.
- fetch_fault  output  1  misalignment fault, optional feature only; tied 0 otherwise.

Behaviour:
- Reset values:
  - pc=RESET_VECTOR; queue empty; outstanding=0; drop_count=0; state=IDLE.
  - Outputs: imem_req_valid=0, inst_valid=0, fetch_fault=0, imem_addr=RESET_VECTOR; inst_data and inst_pc are 0.
- Reset mid-operation discards the queue and all in-flight bookkeeping. Responses arriving after reset are ignored because drop_count=0 and outstanding=0; the memory is reset by the same signal.
- States:
  - IDLE: one cycle after reset release, then RUN.
  - RUN: normal fetch.
  - FAULT: only when the optional feature is enabled.
- Issue rule (RUN): imem_req_valid=1 iff (queue_count + outstanding) < QUEUE_DEPTH and no redirect this cycle. imem_addr=pc.
- Request transfer: on imem_req_valid & imem_req_ready, pc <= pc + PC_STEP (modulo 2^ADDR_WIDTH, wraps silently) and outstanding increments.
- Response handling:
  - drop_count>0: the response is discarded and drop_count decrements.
  - Otherwise: the response is pushed to the queue with its PC, taken from an internal PC FIFO of depth QUEUE_DEPTH.
- Credit rule guarantees the queue never overflows. A push to a full queue is unreachable; assert it in simulation.
- Output: inst_valid = queue not empty. Pop on inst_valid & inst_ready.
- Push and pop in the same cycle are both allowed at any fill level, including full and empty, with zero-cycle bypass disallowed: an empty queue shows the new entry on the next cycle.
- Latency: from request acceptance to inst_valid is memory latency + 1 cycle.
- Redirect (highest priority, any RUN cycle):
  - queue flushed; pc <= redirect_target.
  - drop_count <= drop_count + outstanding, minus 1 if a response arrives that same cycle. That response is dropped.
  - outstanding <= 0; no request is issued that cycle; inst_valid=0 next cycle.
  - A pop in the same cycle as a redirect is ignored.
- Back-to-back redirects: the last one wins. Drop counts accumulate.
- drop_count width is clog2(QUEUE_DEPTH)+1 bits. Saturation is unreachable given the credit rule.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- When defined: a redirect_target with nonzero bits below log2(PC_STEP) moves the state machine to FAULT.
  - FAULT behaviour: fetch_fault=1 (registered); no requests issued; queue flushed; pending responses still dropped.
  - FAULT is left only by reset.
- When undefined:
  - Low target bits are passed unchanged.
  - fetch_fault is constant 0; FAULT state does not exist.

Decomposition:
- Package fetch_pkg:
  - state encoding constants (IDLE, RUN, FAULT);
  - default ADDR_WIDTH, INST_WIDTH and PC_STEP;
  - a clog2 helper function.
- Sub-module fetch_queue:
  - parametrised synchronous FIFO of width INST_WIDTH+ADDR_WIDTH and depth QUEUE_DEPTH;
  - flush input; count output; active-low synchronous reset.
  - Instantiated once for the output queue; the PC-tracking FIFO reuses the same module.

Test Plan:
- Reset then imem latency 1 with inst_ready=1 -> addresses 0,4,8,12 issued on consecutive cycles; inst_pc 0,4,8 appear in order, first at cycle 3 after reset release.
- inst_ready=0 with QUEUE_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0. Raising inst_ready resumes fetch with pc=16.
- Memory latency 3 with redirect to 0x100 while 2 requests are outstanding -> those 2 responses are dropped; the first inst_pc after the redirect is 0x100; no stale PC is delivered.
- Redirect in the same cycle as a response and a pop -> queue empty next cycle; drop_count = outstanding-1; the next delivered PC equals the target.
- PC at 0xFFFFFFFC -> the next request address is 0x00000000.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> fetch_fault=1 next cycle; imem_req_valid stays 0 until reset==0; after reset, fetch restarts at RESET_VECTOR.
